// File: rtl/softmax_exp_sched_if.sv
// Stream, exponent-unit and drain signals of the softmax exponent scheduler.
// The slave modport is the scheduler's view; master is the surrounding fabric.
interface softmax_exp_sched_if #(
  parameter int unsigned SUM_W = 13
) ();
  // Score input stream from the MAC array
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_last;

  // Shared combinational exponent unit
  logic [7:0]       ex_x;
  logic [8:0]       ex_y;

  // Credit-gated output stream to the normalizer
  logic             m_valid;
  logic [8:0]       m_data;
  logic             m_last;
  logic [SUM_W-1:0] m_sum;
  logic             credit_ret;

  // Status
  logic             busy;
  logic             len_err;

  modport master (
    output s_valid, s_data, s_last, ex_y, credit_ret,
    input  s_ready, ex_x, m_valid, m_data, m_last, m_sum, busy, len_err
  );

  modport slave (
    input  s_valid, s_data, s_last, ex_y, credit_ret,
    output s_ready, ex_x, m_valid, m_data, m_last, m_sum, busy, len_err
  );
endinterface

// File: rtl/softmax_exp_sched.sv
// Row scheduler for the attention exponent stage. Fills a row buffer with
// exponentials from the shared ex unit while summing them, then drains the
// row under credit flow control with the row sum attached to every beat.
module softmax_exp_sched #(
  parameter int unsigned ROW_LEN = 8,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned SUM_W   = 13
) (
  input logic                clk,
  input logic                rst,
  softmax_exp_sched_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(ROW_LEN + 1);
  localparam int unsigned IDX_W = $clog2(ROW_LEN);
  localparam int unsigned CRD_W = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(ROW_LEN - 1);
  localparam logic [CRD_W-1:0] CrdMax  = CRD_W'(CREDITS);

  typedef enum logic {StFill, StDrain} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] len_q;
  logic [SUM_W-1:0] acc_q;
  logic [CRD_W-1:0] credit_cnt_q;
  logic [8:0]       row_buf_q [ROW_LEN];

  logic             m_valid_q;
  logic [8:0]       m_data_q;
  logic             m_last_q;
  logic [SUM_W-1:0] m_sum_q;
  logic             len_err_q;

  logic             accept;
  logic             row_end;
  logic             issue;
  logic             last_issue;
  logic [SUM_W-1:0] acc_d;
  logic [CRD_W-1:0] credit_cnt_d;

  // Handshake, row-termination and issue decode
  always_comb begin
    accept     = bus.s_valid && (state_q == StFill);
    // A row also ends when the buffer is full, even without s_last
    row_end    = accept && (bus.s_last || (wr_cnt_q == LastIdx));
    acc_d      = acc_q + SUM_W'(bus.ex_y);
    issue      = (state_q == StDrain) && (credit_cnt_q != '0) && (rd_ptr_q < len_q);
    last_issue = issue && (rd_ptr_q == (len_q - CNT_W'(1)));
  end

  // Credit counter next state: issue and return cancel, returns saturate
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    case ({issue, bus.credit_ret})
      2'b10:   credit_cnt_d = credit_cnt_q - CRD_W'(1);
      2'b01:   credit_cnt_d = (credit_cnt_q == CrdMax) ? credit_cnt_q
                                                       : credit_cnt_q + CRD_W'(1);
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  // Row buffer write; contents are don't-care after reset so it has none
  always_ff @(posedge clk) begin
    if (accept) begin
      row_buf_q[wr_cnt_q[IDX_W-1:0]] <= bus.ex_y;
    end
  end

  // FILL/DRAIN control with registered output beat, sum and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      credit_cnt_q <= CrdMax;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_sum_q      <= '0;
      len_err_q    <= 1'b0;
    end else begin
      credit_cnt_q <= credit_cnt_d;
      len_err_q    <= 1'b0;
      m_valid_q    <= issue;
      case (state_q)
        StFill: begin
          if (accept) begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            acc_q    <= acc_d;
            if (row_end) begin
              state_q   <= StDrain;
              len_q     <= wr_cnt_q + CNT_W'(1);
              m_sum_q   <= acc_d;
              len_err_q <= !bus.s_last;
            end
          end
        end
        StDrain: begin
          if (issue) begin
            m_data_q <= row_buf_q[rd_ptr_q[IDX_W-1:0]];
            m_last_q <= last_issue;
            rd_ptr_q <= rd_ptr_q + CNT_W'(1);
            // Final beat: reopen for the next row in the same edge
            if (last_issue) begin
              state_q  <= StFill;
              wr_cnt_q <= '0;
              rd_ptr_q <= '0;
              acc_q    <= '0;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  // Output drive; ex operand is a straight pass-through of the score
  always_comb begin
    bus.ex_x    = bus.s_data;
    bus.s_ready = (state_q == StFill);
    bus.busy    = (state_q == StDrain) || (wr_cnt_q != '0);
    bus.m_valid = m_valid_q;
    bus.m_data  = m_data_q;
    bus.m_last  = m_last_q;
    bus.m_sum   = m_sum_q;
    bus.len_err = len_err_q;
  end

endmodule
